// File: rtl/dvi_decoder.sv
// dvi_decoder
//   Receive side of a DVI/TMDS link. Each pixel clock it takes one 10-bit word
//   per channel from the deserializer. It finds word alignment per channel by
//   requesting bitslips until a long run of control tokens appears. It then
//   decodes the words into 8-bit blue/green/red plus hsync/vsync/de.
//
// Ports
//   pixelclk    in   1   pixel clock, the only clock
//   rstin       in   1   asynchronous, active-low reset
//   tmds_data0  in  10   blue word, bit0 = first bit on the wire
//   tmds_data1  in  10   green word
//   tmds_data2  in  10   red word
//   bitslip     out  3   one-cycle rotate request, bit n for tmds_data n
//   locked      out  1   all three channels aligned (registered)
//   blue_dout   out  8   decoded blue
//   green_dout  out  8   decoded green
//   red_dout    out  8   decoded red
//   hsync       out  1   blue-channel c0
//   vsync       out  1   blue-channel c1
//   de          out  1   data enable, taken from the blue channel
module dvi_decoder #(
    parameter int CTRL_RUN       = 64,
    parameter int SEARCH_TIMEOUT = 8192,
    parameter int SLIP_WAIT      = 16
) (
    input  logic       pixelclk,
    input  logic       rstin,
    input  logic [9:0] tmds_data0,
    input  logic [9:0] tmds_data1,
    input  logic [9:0] tmds_data2,
    output logic [2:0] bitslip,
    output logic       locked,
    output logic [7:0] blue_dout,
    output logic [7:0] green_dout,
    output logic [7:0] red_dout,
    output logic       hsync,
    output logic       vsync,
    output logic       de
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } ch_state_t;

    // "Last" values: a counter sitting at X-1 means this is its X-th cycle.
    localparam logic [6:0]  RUN_LAST  = 7'(CTRL_RUN - 1);
    localparam logic [12:0] WIN_LAST  = 13'(SEARCH_TIMEOUT - 1);
    localparam logic [12:0] WAIT_LAST = 13'(SLIP_WAIT - 1);

    logic [9:0]      w_word [3];
    logic [2:0]      w_ch_locked;
    logic [2:0]      w_s1_tok;
    logic [2:0][7:0] w_dec;
    logic [1:0]      w_blue_ctl;

    logic [2:0][7:0] r_dout;
    logic [1:0]      r_s1_ctl;
    logic            r_de;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_locked;

    assign w_word[0] = tmds_data0;
    assign w_word[1] = tmds_data1;
    assign w_word[2] = tmds_data2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic       w_tok;
            logic       w_run_done;
            ch_state_t  r_state;
            ch_state_t  w_state_next;
            logic [6:0] r_run;
            logic [6:0] w_run_next;
            // In WAIT the window counter doubles as the settle counter.
            logic [12:0] r_win;
            logic [12:0] w_win_next;
            logic [9:0]  r_s1_word;
            logic        r_s1_tok;
            logic [7:0]  w_d;
            logic [7:0]  w_dec_loc;

            always_comb begin
                case (w_word[gi])
                    10'h354, 10'h0AB, 10'h154, 10'h2AB: w_tok = 1'b1;
                    default:                            w_tok = 1'b0;
                endcase
            end

            assign w_run_done = w_tok && (r_run == RUN_LAST);

            // Alignment FSM. The raw input word feeds it directly, so a run
            // of CTRL_RUN tokens locks on the CTRL_RUN-th edge.
            always_comb begin
                w_state_next = r_state;
                w_run_next   = w_tok ? r_run + 7'd1 : 7'd0;
                w_win_next   = r_win + 13'd1;
                case (r_state)
                    ST_SEARCH: begin
                        // A completed run beats a timeout on the same cycle.
                        if (w_run_done) begin
                            w_state_next = ST_LOCKED;
                            w_run_next   = 7'd0;
                            w_win_next   = 13'd0;
                        end else if (r_win == WIN_LAST) begin
                            w_state_next = ST_SLIP;
                            w_run_next   = 7'd0;
                            w_win_next   = 13'd0;
                        end
                    end
                    ST_SLIP: begin
                        w_state_next = ST_WAIT;
                        w_run_next   = 7'd0;
                        w_win_next   = 13'd0;
                    end
                    ST_WAIT: begin
                        w_run_next = 7'd0;
                        if (r_win == WAIT_LAST) begin
                            w_state_next = ST_SEARCH;
                            w_win_next   = 13'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_run_done) begin
                            w_run_next = 7'd0;
                            w_win_next = 13'd0;
                        end else if (r_win == WIN_LAST) begin
                            w_state_next = ST_SEARCH;
                            w_run_next   = 7'd0;
                            w_win_next   = 13'd0;
                        end
                    end
                    default: begin
                        w_state_next = ST_SEARCH;
                        w_run_next   = 7'd0;
                        w_win_next   = 13'd0;
                    end
                endcase
            end

            always_ff @(posedge pixelclk or negedge rstin) begin
                if (!rstin) begin
                    r_state   <= ST_SEARCH;
                    r_run     <= 7'd0;
                    r_win     <= 13'd0;
                    r_s1_word <= 10'd0;
                    r_s1_tok  <= 1'b0;
                end else begin
                    r_state   <= w_state_next;
                    r_run     <= w_run_next;
                    r_win     <= w_win_next;
                    r_s1_word <= w_word[gi];
                    r_s1_tok  <= w_tok;
                end
            end

            // The pulse comes straight from the state register, so reset
            // removes it immediately rather than at the next edge.
            assign bitslip[gi]     = (r_state == ST_SLIP);
            assign w_ch_locked[gi] = (r_state == ST_LOCKED);
            assign w_s1_tok[gi]    = r_s1_tok;

            // q[9] undoes the DC-balance inversion. q[8] selects XOR or XNOR
            // chaining, which reverses the encoder's transition minimising.
            always_comb begin
                w_d          = r_s1_word[9] ? ~r_s1_word[7:0] : r_s1_word[7:0];
                w_dec_loc    = 8'h00;
                w_dec_loc[0] = w_d[0];
                for (int i = 1; i < 8; i++) begin
                    w_dec_loc[i] = r_s1_word[8] ? (w_d[i] ^ w_d[i-1])
                                                : ~(w_d[i] ^ w_d[i-1]);
                end
            end
            assign w_dec[gi] = w_dec_loc;
        end
    endgenerate

    // Only blue carries sync. Green and red control bits are discarded.
    always_comb begin
        case (tmds_data0)
            10'h0AB: w_blue_ctl = 2'b01;
            10'h154: w_blue_ctl = 2'b10;
            10'h2AB: w_blue_ctl = 2'b11;
            default: w_blue_ctl = 2'b00;
        endcase
    end

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            r_dout   <= '0;
            r_s1_ctl <= 2'b00;
            r_de     <= 1'b0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_locked <= &w_ch_locked;
            r_s1_ctl <= w_blue_ctl;
            for (int c = 0; c < 3; c++) begin
                r_dout[c] <= w_s1_tok[c] ? 8'h00 : w_dec[c];
            end
            if (w_s1_tok[0]) begin
                r_de    <= 1'b0;
                r_hsync <= r_s1_ctl[0];
                r_vsync <= r_s1_ctl[1];
            end else begin
                // On data words, sync keeps the last token's value.
                r_de <= 1'b1;
            end
        end
    end

    // The pipeline keeps running while unlocked. Only the outputs are masked.
    assign locked     = r_locked;
    assign blue_dout  = r_locked ? r_dout[0] : 8'h00;
    assign green_dout = r_locked ? r_dout[1] : 8'h00;
    assign red_dout   = r_locked ? r_dout[2] : 8'h00;
    assign de         = r_locked & r_de;
    assign hsync      = r_locked & r_hsync;
    assign vsync      = r_locked & r_vsync;

endmodule

// File: tb/tb_dvi_decoder.sv
module tb_dvi_decoder;

    localparam int CTRL_RUN       = 64;
    localparam int SEARCH_TIMEOUT = 8192;
    localparam int SLIP_WAIT      = 16;

    logic       pixelclk = 1'b0;
    logic       rstin = 1'b0;
    logic [9:0] tmds_data0 = 10'h354;
    logic [9:0] tmds_data1 = 10'h354;
    logic [9:0] tmds_data2 = 10'h354;
    logic [2:0] bitslip;
    logic       locked;
    logic [7:0] blue_dout, green_dout, red_dout;
    logic       hsync, vsync, de;

    int total = 0;
    int bad   = 0;

    dvi_decoder #(
        .CTRL_RUN(CTRL_RUN), .SEARCH_TIMEOUT(SEARCH_TIMEOUT), .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .pixelclk(pixelclk), .rstin(rstin),
        .tmds_data0(tmds_data0), .tmds_data1(tmds_data1), .tmds_data2(tmds_data2),
        .bitslip(bitslip), .locked(locked),
        .blue_dout(blue_dout), .green_dout(green_dout), .red_dout(red_dout),
        .hsync(hsync), .vsync(vsync), .de(de)
    );

    always #5 pixelclk = ~pixelclk;

    typedef struct {
        logic [9:0] w0, w1, w2;
        logic [7:0] eb, eg, er;
        logic       ede, ehs, evs;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge pixelclk);
        @(negedge pixelclk);
    endtask

    task automatic drive(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        tmds_data0 = a;
        tmds_data1 = b;
        tmds_data2 = c;
    endtask

    // TMDS encoder: transition minimising plus an explicitly chosen q[9].
    function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
        logic [7:0] qm;
        logic       use_xnor;
        int         n1;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        return inv ? {1'b1, ~use_xnor, ~qm} : {1'b0, ~use_xnor, qm};
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int k);
        logic [19:0] t;
        t = {w, w} >> k;
        return t[9:0];
    endfunction

    task automatic refresh_tokens(input int n);
        drive(10'h354, 10'h354, 10'h354);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n, slips, other, pulses, last_pulse, off;
        logic [7:0] vb, vg, vr;
        logic [7:0] pb, pg, pr;

        // Expected values are written out by hand. Data words come from the
        // encoder: A5 -> 163 / 39C, 00 -> 100 / 3FF, FF -> 0FF / 200.
        tbl[0] = '{10'h354, 10'h354, 10'h354, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{10'h0AB, 10'h354, 10'h354, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{10'h163, 10'h100, 10'h0FF, 8'hA5, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{10'h39C, 10'h3FF, 10'h200, 8'hA5, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{10'h154, 10'h354, 10'h354, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{10'h2AB, 10'h354, 10'h354, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{10'h100, 10'h163, 10'h39C, 8'h00, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{10'h354, 10'h354, 10'h354, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

        // 1. Reset with tokens driven, then lock on aligned tokens.
        rstin = 1'b0;
        drive(10'h354, 10'h354, 10'h354);
        tick(); tick(); tick();
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_bitslip", {29'd0, bitslip}, 32'd0);
        check("rst_outputs", {5'd0, blue_dout, green_dout, red_dout, de, hsync, vsync}, 32'd0);
        rstin = 1'b1;
        slips = 0;
        n = 0;
        while (n < CTRL_RUN + 2 && !locked) begin
            tick();
            n++;
            if (bitslip != 3'b000) slips++;
        end
        check("initial_lock", {31'd0, locked}, 32'd1);
        check("lock_not_early", {31'd0, (n >= CTRL_RUN)}, 32'd1);
        check("initial_slips", slips, 32'd0);

        // 3/4. Table of token and data vectors, each held for two edges.
        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].w0, tbl[k].w1, tbl[k].w2);
            tick(); tick();
            check($sformatf("vec%0d", k),
                  {5'd0, blue_dout, green_dout, red_dout, de, hsync, vsync},
                  {5'd0, tbl[k].eb, tbl[k].eg, tbl[k].er, tbl[k].ede, tbl[k].ehs, tbl[k].evs});
        end

        // 4. All 256 byte values, streamed back to back with both q[9] polarities.
        refresh_tokens(CTRL_RUN + 6);
        check("still_locked", {31'd0, locked}, 32'd1);
        pb = 8'h00; pg = 8'h00; pr = 8'h00;
        for (int v = 0; v <= 256; v++) begin
            vb = 8'(v);
            vg = 8'(v + 85);
            vr = ~8'(v);
            if (v < 256) drive(enc(vb, vb[0]), enc(vg, vb[1]), enc(vr, vb[2]));
            else         drive(10'h354, 10'h354, 10'h354);
            tick();
            // After one edge the outputs show the word driven one cycle earlier.
            if (v >= 1)
                check($sformatf("sweep%0d", v - 1),
                      {5'd0, blue_dout, green_dout, red_dout, de, hsync, vsync},
                      {5'd0, pb, pg, pr, 1'b1, 1'b0, 1'b0});
            pb = vb; pg = vg; pr = vr;
        end

        // 5. Data only: locked must fall after the window with no slips, then relock.
        refresh_tokens(CTRL_RUN + 6);
        drive(10'h163, 10'h100, 10'h0FF);
        slips = 0;
        n = 0;
        while (n < SEARCH_TIMEOUT + 8 && locked) begin
            tick();
            n++;
            if (bitslip != 3'b000) slips++;
        end
        check("timeout_unlock", {31'd0, locked}, 32'd0);
        check("timeout_not_early", {31'd0, (n >= SEARCH_TIMEOUT - CTRL_RUN - 8)}, 32'd1);
        check("timeout_slips", slips, 32'd0);
        tick();
        check("unlocked_forced0", {5'd0, blue_dout, green_dout, red_dout, de, hsync, vsync}, 32'd0);
        drive(10'h354, 10'h354, 10'h354);
        n = 0;
        while (n < CTRL_RUN + 2 && !locked) begin
            tick();
            n++;
        end
        check("relock", {31'd0, locked}, 32'd1);
        check("relock_not_early", {31'd0, (n >= CTRL_RUN)}, 32'd1);

        // 2. Green rotated by 3. The model rotates back one bit per slip.
        rstin = 1'b0;
        tick();
        off = 3;
        drive(10'h354, rot(10'h354, off), 10'h354);
        rstin = 1'b1;
        pulses = 0;
        other = 0;
        last_pulse = 0;
        n = 0;
        while (n < 4 * (SEARCH_TIMEOUT + SLIP_WAIT + 1) && !locked) begin
            tick();
            n++;
            if (bitslip[0] || bitslip[2]) other++;
            if (bitslip[1]) begin
                pulses++;
                if (pulses == 1)
                    check("first_slip_time", n, SEARCH_TIMEOUT);
                else
                    check($sformatf("slip_gap%0d", pulses),
                          {31'd0, (n - last_pulse >= SLIP_WAIT + SEARCH_TIMEOUT) &&
                                  (n - last_pulse <= SLIP_WAIT + SEARCH_TIMEOUT + 4)}, 32'd1);
                last_pulse = n;
                off = (off + 9) % 10;
                drive(10'h354, rot(10'h354, off), 10'h354);
            end
        end
        check("slip_count", pulses, 32'd3);
        check("slip_other_ch", other, 32'd0);
        check("slip_locked", {31'd0, locked}, 32'd1);

        // 6. Reset during the SLIP cycle clears the pulse immediately.
        rstin = 1'b0;
        tick();
        drive(10'h354, rot(10'h354, 3), 10'h354);
        rstin = 1'b1;
        n = 0;
        while (n < SEARCH_TIMEOUT + 4 && !bitslip[1]) begin
            tick();
            n++;
        end
        check("slip_seen", {31'd0, bitslip[1]}, 32'd1);
        rstin = 1'b0;
        #1;
        check("async_slip_clear", {29'd0, bitslip}, 32'd0);
        check("async_lock_clear", {31'd0, locked}, 32'd0);
        tick(); tick();
        rstin = 1'b1;
        n = 0;
        while (n < SEARCH_TIMEOUT + 4 && !bitslip[1]) begin
            tick();
            n++;
        end
        check("restart_slip_time", n, SEARCH_TIMEOUT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
